// File: rtl/clock_display_scan_pkg.sv
// Shared display constants: segment patterns, anode idle value, mode encodings
// and the per-frame snapshot record.
package clock_defs;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'hF;

  typedef enum logic {
    MODE_MMSS = 1'b0,
    MODE_HHMM = 1'b1
  } disp_mode_t;

  // Time digits and mode frozen for one scan frame
  typedef struct packed {
    disp_mode_t  mode;
    logic [3:0]  sec_unit;
    logic [3:0]  sec_ten;
    logic [3:0]  min_unit;
    logic [3:0]  min_ten;
    logic [3:0]  hour_unit;
    logic [1:0]  hour_ten;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import clock_defs::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup, dash for codes above 9
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit 7-segment scanner for the clock core. Digits are frozen
// once per frame so carry ripples in the clock never tear the display; each
// slot starts with a short all-dark guard window to hide segment switching.
module clock_display_scan
  import clock_defs::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int GUARD           = 2,
  parameter int BLANK_LEAD_ZERO = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       display_mode,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] hour_unit,
  input  logic [1:0] hour_ten,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             tc, frame_end;
  snap_t            snap, snap_nxt, snap_live;
  logic [3:0]       cur_digit;
  logic [6:0]       seg_dec;
  logic [3:0]       an_nxt;
  logic             dp_nxt;

  // Digit shown in a slot for the given snapshot and window
  function automatic logic [3:0] digit_sel(input snap_t s, input logic [1:0] slot);
    logic [3:0] d;
    if (s.mode == MODE_HHMM) begin
      case (slot)
        2'd0:    d = s.min_unit;
        2'd1:    d = s.min_ten;
        2'd2:    d = s.hour_unit;
        default: d = {2'b00, s.hour_ten};
      endcase
    end else begin
      case (slot)
        2'd0:    d = s.sec_unit;
        2'd1:    d = s.sec_ten;
        2'd2:    d = s.min_unit;
        default: d = s.min_ten;
      endcase
    end
    return d;
  endfunction

  // Leading-zero hour digit is suppressed in HH:MM mode when enabled
  function automatic logic slot_blank(input snap_t s, input logic [1:0] slot);
    return (BLANK_LEAD_ZERO != 0) && (s.mode == MODE_HHMM) &&
           (s.hour_ten == 2'd0) && (slot == 2'd3);
  endfunction

  // Prescaler/slot sequencing and next-frame snapshot selection
  always_comb begin
    snap_live.mode      = disp_mode_t'(display_mode);
    snap_live.sec_unit  = sec_unit;
    snap_live.sec_ten   = sec_ten;
    snap_live.min_unit  = min_unit;
    snap_live.min_ten   = min_ten;
    snap_live.hour_unit = hour_unit;
    snap_live.hour_ten  = hour_ten;

    tc        = (cnt == CNT_TC);
    frame_end = tc && (idx == 2'd3);
    cnt_nxt   = tc ? '0 : cnt + 1'b1;
    idx_nxt   = tc ? idx + 2'd1 : idx;
    snap_nxt  = frame_end ? snap_live : snap;
  end

  // Anode and colon are registered from next-state values so they line up
  // exactly with the prescaler/slot they describe
  always_comb begin
    an_nxt = AN_OFF;
    if (cnt_nxt >= GUARD_C && !slot_blank(snap_nxt, idx_nxt))
      an_nxt = ~(4'b0001 << idx_nxt);
    dp_nxt = !((an_nxt[2] == 1'b0) && (snap_nxt.sec_unit[0] == 1'b0));
  end

  assign cur_digit = digit_sel(snap, idx);

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (seg_dec)
  );

  // Scan state, frame snapshot and registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= 2'd0;
      snap <= '0;
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp   <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      snap <= snap_nxt;
      an   <= an_nxt;
      // One cycle behind idx; the guard window keeps the stale pattern dark
      seg  <= slot_blank(snap, idx) ? SEG_OFF : seg_dec;
      dp   <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized and directed bench for clock_display_scan against a timeline
// model: position in the scan is derived from the cycle count since reset.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int G  = 1;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       display_mode = 1'b0;
  logic [3:0] sec_unit = '0, sec_ten = '0, min_unit = '0, min_ten = '0, hour_unit = '0;
  logic [1:0] hour_ten = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit       mode;
    bit [3:0] su, st, mu, mt, hu;
    bit [1:0] ht;
  } tsnap_t;

  tsnap_t snap_m, prev_m;
  int     t, prev_t;
  bit [6:0] seg_tab [16];

  clock_display_scan #(.SCAN_DIV(SD), .GUARD(G), .BLANK_LEAD_ZERO(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .display_mode (display_mode),
    .sec_unit     (sec_unit),
    .sec_ten      (sec_ten),
    .min_unit     (min_unit),
    .min_ten      (min_ten),
    .hour_unit    (hour_unit),
    .hour_ten     (hour_ten),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic tsnap_t zero_snap();
    tsnap_t s;
    s.mode = 0; s.su = 0; s.st = 0; s.mu = 0; s.mt = 0; s.hu = 0; s.ht = 0;
    return s;
  endfunction

  function automatic tsnap_t live_inputs();
    tsnap_t s;
    s.mode = display_mode; s.su = sec_unit; s.st = sec_ten; s.mu = min_unit;
    s.mt = min_ten; s.hu = hour_unit; s.ht = hour_ten;
    return s;
  endfunction

  task automatic apply(input tsnap_t s);
    display_mode = s.mode; sec_unit = s.su; sec_ten = s.st; min_unit = s.mu;
    min_ten = s.mt; hour_unit = s.hu; hour_ten = s.ht;
  endtask

  // Rightmost-first list of the four displayed values for a window
  function automatic bit [3:0] slot_digit(input tsnap_t s, input int slot);
    bit [3:0] v [4];
    if (s.mode) begin
      v[0] = s.mu; v[1] = s.mt; v[2] = s.hu; v[3] = {2'b00, s.ht};
    end else begin
      v[0] = s.su; v[1] = s.st; v[2] = s.mu; v[3] = s.mt;
    end
    return v[slot];
  endfunction

  function automatic bit blanked(input tsnap_t s, input int slot);
    return s.mode && (s.ht == 0) && (slot == 3);
  endfunction

  // One clock edge: advance the model, then compare all three outputs
  task automatic step();
    int cnt, slot, pslot;
    bit [3:0] an_e;
    bit [6:0] seg_e;
    bit       dp_e;
    @(posedge clk);
    prev_m = snap_m;
    prev_t = t;
    if (t % FRAME == FRAME - 1) snap_m = live_inputs();
    t++;
    #1;
    cnt  = t % SD;
    slot = (t / SD) % 4;
    if (cnt < G || blanked(snap_m, slot)) an_e = 4'hF;
    else an_e = ~(4'b0001 << slot);
    dp_e  = !(an_e[2] == 1'b0 && snap_m.su[0] == 1'b0);
    pslot = (prev_t / SD) % 4;
    seg_e = blanked(prev_m, pslot) ? 7'h7F : seg_tab[slot_digit(prev_m, pslot)];
    chk("an", 32'(an), 32'(an_e));
    chk("seg", 32'(seg), 32'(seg_e));
    chk("dp", 32'(dp), 32'(dp_e));
  endtask

  // Run until the next frame boundary edge has loaded the current inputs
  task automatic to_boundary();
    while (t % FRAME != FRAME - 1) step();
    step();
  endtask

  // After a boundary, check spec literals mid-slot for each of the four slots
  task automatic literal_frame(input string tag, input bit [3:0] an_l [4],
                               input bit [6:0] seg_l [4], input bit dp_l [4]);
    to_boundary();
    for (int s = 0; s < 4; s++) begin
      while (t % SD != 2) step();
      chk({tag, "_an"}, 32'(an), 32'(an_l[s]));
      chk({tag, "_seg"}, 32'(seg), 32'(seg_l[s]));
      chk({tag, "_dp"}, 32'(dp), 32'(dp_l[s]));
      step();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    snap_m = zero_snap();
    prev_m = snap_m;
  endtask

  initial begin
    tsnap_t s;
    bit [3:0] an_l [4];
    bit [6:0] seg_l [4];
    bit       dp_l [4];

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    t = 0;

    // Reset held with clock running
    apply('{1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 2'd1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
    end

    // First frame shows the zero snapshot, then 59:37 in mode 0
    apply('{0, 4'd7, 4'd3, 4'd9, 4'd5, 4'd0, 2'd0});
    release_reset();
    an_l  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_l = '{7'b1111000, 7'b0110000, 7'b0010000, 7'b0010010};
    dp_l  = '{1, 1, 1, 1};
    literal_frame("mmss", an_l, seg_l, dp_l);

    // Mode 1, 08:45 with even second: leading zero blanked, colon lit
    apply('{1, 4'd4, 4'd0, 4'd5, 4'd4, 4'd8, 2'd0});
    an_l  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    seg_l = '{7'b0010010, 7'b0011001, 7'b0000000, 7'h7F};
    dp_l  = '{1, 1, 0, 1};
    literal_frame("hhmm", an_l, seg_l, dp_l);

    // Non-BCD minute unit shows a dash only in its own slot
    apply('{0, 4'd7, 4'd3, 4'hC, 4'd5, 4'd0, 2'd0});
    an_l  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_l = '{7'b1111000, 7'b0110000, 7'b0111111, 7'b0010010};
    dp_l  = '{1, 1, 1, 1};
    literal_frame("dash", an_l, seg_l, dp_l);

    // Mid-frame digit and mode change; model holds old values until boundary
    apply('{0, 4'd7, 4'd3, 4'd9, 4'd5, 4'd2, 2'd1});
    to_boundary();
    for (int i = 0; i < 5; i++) step();
    apply('{1, 4'd7, 4'd3, 4'd0, 4'd5, 4'd2, 2'd1});
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Random digits and mode, changed at random points within frames
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          s.mode = 1'($urandom_range(0, 1));
          s.su = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          s.st = 4'($urandom_range(0, 5));
          s.mu = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          s.mt = 4'($urandom_range(0, 5));
          s.hu = 4'($urandom_range(0, 9));
          s.ht = 2'($urandom_range(0, 3));
          apply(s);
        end
        step();
      end
    end

    // Asynchronous reset mid-slot, outputs drop without a clock edge
    while (t % SD != 2) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'h1);
    @(posedge clk);
    #1;
    chk("arst_hold_an", 32'(an), 32'hF);
    release_reset();
    for (int i = 0; i < 3 * FRAME; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
